pmp_seq_checker: RTL and testbench
==================================

# pmp_seq_checker

Sequential PMP access checker. It time-multiplexes one `pmp_entry` match instance across all configured PMP regions, scanning one entry per cycle in priority order (entry 0 first). It returns allow/deny plus the matching entry index through a valid/ready response. It sits between the MMU/LSU request path and the PMP CSR file, where area matters more than single-cycle checks.

## Interface
Parameters:
- NR_ENTRIES, 8, number of PMP entries scanned; legal range 1..16.

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  abort current check (CSR write / pipeline flush)
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  block can accept a request
- req_addr_i  in  34  physical address
- req_access_i  in  3  requested access {X,W,R}, one-hot
- req_priv_m_i  in  1  request issued in M-mode
- pmpaddr_i  in  NR_ENTRIES*32  pmpaddr CSRs, entry i at [32i+:32]
- pmpcfg_i  in  NR_ENTRIES*8  pmpcfg bytes: [0]R [1]W [2]X [4:3]A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT) [7]L
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer accepts result
- resp_allow_o  out  1  access permitted
- resp_matched_o  out  1  some entry matched
- resp_idx_o  out  4  lowest matching entry index (0 if none)

## Operation
- FSM: IDLE, SCAN, RESP.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, latch addr/access/priv, clear idx counter, go to SCAN.
- SCAN: the entry under test is idx. It is fed to the shared matcher with conf_addr = pmpaddr[idx], prev = (idx==0) ? 0 : pmpaddr[idx-1], mode = cfg[idx].A. An OFF entry never matches but still consumes its cycle.
  - First match at idx k: record k and cfg[k].
  - After the scan ends (see Configuration), go to RESP.
- Permission rule, given a match at entry k:
  - If req_priv_m_i=1 and L=0: allow=1.
  - Otherwise: allow = |(req_access & cfg[k].{X,W,R}).
- No match: allow = req_priv_m_i. matched=0, idx=0.
- RESP: resp_valid_o=1, and outputs are held stable until resp_ready_i. On the handshake, go to IDLE. No new request is accepted in the same cycle.
- flush_i in SCAN or RESP: go to IDLE next cycle. Any pending response is discarded. flush_i overrides a simultaneous resp_ready_i. flush_i in IDLE has no effect; a same-cycle request is still accepted.
- pmpaddr_i/pmpcfg_i are read live, not snapshotted. Software must assert flush_i on CSR writes; a result computed across a config change without flush is unspecified.
- Address arithmetic: TOR compares against pmpaddr<<2 in 34 bits. NAPOT size = trailing_ones+3. NA4 size = 2.

## Timing
- Reset: state=IDLE, req_ready_o=1, resp_valid_o=0, resp_allow_o=0, resp_matched_o=0, resp_idx_o=0. Reset mid-scan behaves like flush.
- Request accepted in cycle T; entry i is evaluated in cycle T+1+i.
- Early exit on match at k: resp_valid_o rises at T+2+k.
- No match: resp_valid_o rises at T+1+NR_ENTRIES.
- Throughput: at most one check per (latency+1) cycles. Not pipelined.
- The matcher is purely combinational. idx, match bit and cfg are registered at the end of each SCAN cycle.

## Configuration
- PMP_SEQ_EARLY_EXIT_EN defined: the scan stops at the first matching entry, and latency depends on k.
- PMP_SEQ_EARLY_EXIT_EN undefined: all NR_ENTRIES are always scanned, and later matches do not overwrite the first. Latency is constant at NR_ENTRIES+1 (no address-dependent timing). Results are identical in both builds.

## Test plan
- Entry0 NAPOT, pmpaddr=0x2000_01FF, cfg R: user read 0x8000_0123 -> allow=1, matched=1, idx=0. resp_valid 2 cycles after accept (early exit) or NR_ENTRIES+1 (otherwise). Same address with W -> allow=0.
- Entry0 OFF pmpaddr=0x2000_0400; entry1 TOR pmpaddr=0x2000_1000, cfg RW. User write 0x8000_3FFC -> allow=1, idx=1. Address 0x8000_4000 -> matched=0, allow=0. Address 0x8000_0FFC -> no match.
- All entries OFF: M-mode fetch of 0x0 -> allow=1, matched=0. User fetch -> allow=0.
- Entry2 NA4 at 0x8000_0010, cfg R with L=1: M-mode X at 0x8000_0010 -> allow=0, idx=2. Same with L=0 -> allow=1.
- Overlap: entry0 NAPOT denying W and entry3 allowing W cover the same address -> idx=0, allow=0.
- Handshake/flush: hold resp_ready_i=0 for 3 cycles -> outputs stable, req_ready_o=0. Assert flush_i in the 2nd SCAN cycle -> no resp_valid_o, and req_ready_o=1 the next cycle.

Source files
------------

// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one shared matcher walks the entries in priority order.
// Optional macro PMP_SEQ_EARLY_EXIT_EN stops the scan at the first matching entry.

module pmp_entry (
    input  logic [33:0] addr_i,
    input  logic [31:0] conf_addr_i,
    input  logic [31:0] prev_i,
    input  logic [1:0]  mode_i,
    output logic        match_o
);

    logic [33:0] napot_mask;
    logic [33:0] base;
    logic [33:0] lo;

    // Address-range match for one entry; NAPOT low-bit mask comes from the trailing ones.
    always_comb begin
        match_o    = 1'b0;
        base       = {conf_addr_i, 2'b00};
        lo         = {prev_i, 2'b00};
        napot_mask = {conf_addr_i ^ (conf_addr_i + 32'd1), 2'b11};
        unique case (mode_i)
            2'b00: match_o = 1'b0;
            2'b01: match_o = (addr_i >= lo) && (addr_i < base);
            2'b10: match_o = (addr_i[33:2] == conf_addr_i);
            2'b11: match_o = (((addr_i ^ base) & ~napot_mask) == 34'd0);
        endcase
    end

endmodule

module pmp_seq_checker #(
    parameter int unsigned NR_ENTRIES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [33:0]                req_addr_i,
    input  logic [2:0]                 req_access_i,
    input  logic                       req_priv_m_i,
    input  logic [NR_ENTRIES*32-1:0]   pmpaddr_i,
    input  logic [NR_ENTRIES*8-1:0]    pmpcfg_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic                       resp_allow_o,
    output logic                       resp_matched_o,
    output logic [3:0]                 resp_idx_o
);

    localparam int unsigned IW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_e;

    state_e          state_q;
    state_e          state_d;

    logic [IW-1:0]   idx_q;
    logic [33:0]     addr_q;
    logic [2:0]      access_q;
    logic            priv_q;
    logic            found_q;
    logic [3:0]      hit_idx_q;
    logic [2:0]      hit_xwr_q;
    logic            hit_l_q;

    logic [31:0]     addr_arr [NR_ENTRIES];
    logic [1:0]      mode_arr [NR_ENTRIES];
    logic [2:0]      xwr_arr  [NR_ENTRIES];
    logic            l_arr    [NR_ENTRIES];
    logic [NR_ENTRIES-1:0] unused_cfg;

    logic [31:0]     cur_conf;
    logic [31:0]     cur_prev;
    logic            cur_match;
    logic            last;
    logic            scan_done;

    for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_unpack
        assign addr_arr[g]   = pmpaddr_i[32*g +: 32];
        assign xwr_arr[g]    = pmpcfg_i[8*g +: 3];
        assign mode_arr[g]   = pmpcfg_i[8*g+3 +: 2];
        assign l_arr[g]      = pmpcfg_i[8*g+7];
        assign unused_cfg[g] = ^pmpcfg_i[8*g+5 +: 2];
    end

    assign cur_conf = addr_arr[idx_q];
    assign cur_prev = (idx_q == '0) ? 32'd0 : addr_arr[idx_q - IW'(1)];
    assign last     = (idx_q == IW'(NR_ENTRIES - 1));

    pmp_entry u_match (
        .addr_i      (addr_q),
        .conf_addr_i (cur_conf),
        .prev_i      (cur_prev),
        .mode_i      (mode_arr[idx_q]),
        .match_o     (cur_match)
    );

`ifdef PMP_SEQ_EARLY_EXIT_EN
    assign scan_done = last | cur_match;
`else
    assign scan_done = last;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush beats a simultaneous response handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) state_d = SCAN;
            end
            SCAN: begin
                if (flush_i)        state_d = IDLE;
                else if (scan_done) state_d = RESP;
            end
            RESP: begin
                if (flush_i || resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, scan index and first-hit capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q     <= '0;
            addr_q    <= '0;
            access_q  <= '0;
            priv_q    <= 1'b0;
            found_q   <= 1'b0;
            hit_idx_q <= '0;
            hit_xwr_q <= '0;
            hit_l_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q    <= req_addr_i;
                        access_q  <= req_access_i;
                        priv_q    <= req_priv_m_i;
                        idx_q     <= '0;
                        found_q   <= 1'b0;
                        hit_idx_q <= '0;
                        hit_xwr_q <= '0;
                        hit_l_q   <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!flush_i) begin
                        if (cur_match && !found_q) begin
                            found_q   <= 1'b1;
                            hit_idx_q <= 4'(idx_q);
                            hit_xwr_q <= xwr_arr[idx_q];
                            hit_l_q   <= l_arr[idx_q];
                        end
                        if (!last) idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign resp_valid_o   = (state_q == RESP);
    assign resp_matched_o = found_q;
    assign resp_idx_o     = hit_idx_q;
    assign resp_allow_o   = found_q
                          ? ((priv_q && !hit_l_q) || (|(access_q & hit_xwr_q)))
                          : priv_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Randomized bench for pmp_seq_checker against a region-level reference model.
// Honours PMP_SEQ_EARLY_EXIT_EN when computing expected latency.

module tb_pmp_seq_checker;

    localparam int N = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [33:0]         req_addr = '0;
    logic [2:0]          req_access = 3'b001;
    logic                req_priv = 1'b0;
    logic [N*32-1:0]     pmpaddr;
    logic [N*8-1:0]      pmpcfg;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic                resp_allow;
    logic                resp_matched;
    logic [3:0]          resp_idx;

    logic [31:0]         pa [N];
    logic [7:0]          pc [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Pack the bench's CSR image into the flat ports.
    always_comb begin
        pmpaddr = '0;
        pmpcfg  = '0;
        for (int i = 0; i < N; i++) begin
            pmpaddr[32*i +: 32] = pa[i];
            pmpcfg[8*i +: 8]    = pc[i];
        end
    end

    pmp_seq_checker #(.NR_ENTRIES(N)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_access_i   (req_access),
        .req_priv_m_i   (req_priv),
        .pmpaddr_i      (pmpaddr),
        .pmpcfg_i       (pmpcfg),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_allow_o   (resp_allow),
        .resp_matched_o (resp_matched),
        .resp_idx_o     (resp_idx)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {allow, matched, idx[3:0]} from the region rules.
    function automatic logic [5:0] model(input logic [33:0] a,
                                         input logic [2:0] acc,
                                         input logic m);
        logic [63:0] av;
        logic [63:0] lo;
        logic [63:0] hi;
        logic        hit;
        logic        al;
        int          t;
        int          sz;
        av = {30'd0, a};
        for (int i = 0; i < N; i++) begin
            hit = 1'b0;
            hi  = {30'd0, pa[i], 2'b00};
            case (pc[i][4:3])
                2'd1: begin
                    lo  = (i == 0) ? 64'd0 : {30'd0, pa[i-1], 2'b00};
                    hit = (av >= lo) && (av < hi);
                end
                2'd2: hit = ((av >> 2) == {32'd0, pa[i]});
                2'd3: begin
                    t = 0;
                    while (t < 32 && pa[i][t]) t++;
                    sz  = t + 3;
                    hit = (sz >= 34) ? 1'b1 : ((av >> sz) == (hi >> sz));
                end
                default: hit = 1'b0;
            endcase
            if (hit) begin
                if (m && !pc[i][7]) al = 1'b1;
                else al = |(acc & pc[i][2:0]);
                return {al, 1'b1, 4'(i)};
            end
        end
        return {m, 1'b0, 4'd0};
    endfunction

    function automatic int exp_lat(input logic [5:0] e);
`ifdef PMP_SEQ_EARLY_EXIT_EN
        return e[4] ? int'(e[3:0]) + 2 : N + 1;
`else
        return N + 1;
`endif
    endfunction

    task automatic clr_cfg();
        for (int i = 0; i < N; i++) begin
            pa[i] = '0;
            pc[i] = '0;
        end
    endtask

    task automatic run(input string tag, input logic [33:0] a,
                       input logic [2:0] acc, input logic m, input int hold);
        logic [5:0] e;
        int         lat;
        e = model(a, acc, m);
        @(negedge clk);
        chk({tag, "_rdy"}, req_ready, 1);
        req_addr   = a;
        req_access = acc;
        req_priv   = m;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat(e));
        if (resp_valid) begin
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                chk({tag, "_allow"}, resp_allow, e[5]);
                chk({tag, "_match"}, resp_matched, e[4]);
                chk({tag, "_idx"}, resp_idx, e[3:0]);
                chk({tag, "_busy"}, {req_ready, resp_valid}, 2'b01);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            chk({tag, "_done"}, {req_ready, resp_valid}, 2'b10);
        end
    endtask

    task automatic rand_cfg();
        int t;
        logic [1:0] md;
        for (int i = 0; i < N; i++) begin
            md    = 2'($urandom_range(0, 3));
            pc[i] = {1'($urandom), 2'b00, md, 3'($urandom)};
            pa[i] = 32'h2000_0000 | ($urandom & 32'h0000_0FFF);
            if (md == 2'd3) begin
                t = $urandom_range(0, 10);
                pa[i] = (pa[i] & ~((32'd1 << (t + 1)) - 32'd1))
                      | ((32'd1 << t) - 32'd1);
            end
        end
    endtask

    initial begin
        int         seen;
        int         j;
        logic [33:0] a;
        clr_cfg();
        repeat (2) @(negedge clk);
        chk("rst_out", {req_ready, resp_valid, resp_allow, resp_matched, resp_idx},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
        rst_n = 1'b1;

        pa[0] = 32'h2000_01FF; pc[0] = 8'h19;
        run("napot_r", 34'h0_8000_0123, 3'b001, 1'b0, 3);
        run("napot_w", 34'h0_8000_0123, 3'b010, 1'b0, 3);

        clr_cfg();
        pa[0] = 32'h2000_0400; pc[0] = 8'h00;
        pa[1] = 32'h2000_1000; pc[1] = 8'h0B;
        run("tor_in", 34'h0_8000_3FFC, 3'b010, 1'b0, 1);
        run("tor_top", 34'h0_8000_4000, 3'b010, 1'b0, 0);
        run("tor_low", 34'h0_8000_0FFC, 3'b010, 1'b0, 0);

        clr_cfg();
        run("off_m", 34'h0, 3'b100, 1'b1, 0);
        run("off_u", 34'h0, 3'b100, 1'b0, 0);

        pa[2] = 32'h2000_0004; pc[2] = 8'h91;
        run("na4_lock", 34'h0_8000_0010, 3'b100, 1'b1, 0);
        pc[2] = 8'h11;
        run("na4_unl", 34'h0_8000_0010, 3'b100, 1'b1, 0);

        clr_cfg();
        pa[0] = 32'h2000_01FF; pc[0] = 8'h19;
        pa[3] = 32'h2000_01FF; pc[3] = 8'h1B;
        run("overlap", 34'h0_8000_0123, 3'b010, 1'b0, 2);

        // Flush during the second scan cycle.
        clr_cfg();
        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_scan", {req_ready, resp_valid}, 2'b10);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("flush_noresp", seen, 0);

        // Flush in RESP wins over resp_ready.
        pa[0] = 32'h2000_01FF; pc[0] = 8'h19;
        req_addr = 34'h0_8000_0123;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        j = 0;
        while (!resp_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("flush_resp_seen", resp_valid, 1);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b0;
        chk("flush_resp", {req_ready, resp_valid}, 2'b10);

        // Flush in IDLE does not block a same-cycle request.
        flush = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_idle", req_ready, 0);
        j = 0;
        while (!resp_valid && j < 40) begin
            @(negedge clk);
            j++;
        end
        chk("flush_idle_resp", resp_valid, 1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        // Reset in the middle of a scan.
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid", {req_ready, resp_valid, resp_allow, resp_matched, resp_idx},
            {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

        for (int it = 0; it < 150; it++) begin
            if (it % 10 == 0) rand_cfg();
            j = $urandom_range(0, N - 1);
            if ($urandom_range(0, 4) == 0) a = 34'($urandom);
            else a = {pa[j], 2'b00} + 34'($urandom_range(0, 64)) - 34'd32;
            run("rnd", a, 3'b001 << $urandom_range(0, 2), 1'($urandom),
                $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
